// File: rtl/mips_cpu_hilo_muldiv.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// Define MIPS_HILO_FAST_MULT_EN for single-cycle MUL/MULU; divide stays iterative.
module mips_cpu_hilo_muldiv #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [4:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);

   localparam logic [4:0] OP_MUL  = 5'd2;
   localparam logic [4:0] OP_DIV  = 5'd3;
   localparam logic [4:0] OP_MULU = 5'd22;
   localparam logic [4:0] OP_DIVU = 5'd23;
   localparam logic [4:0] OP_MTHI = 5'd24;
   localparam logic [4:0] OP_MTLO = 5'd25;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIXUP} state_t;

   state_t               state_q, state_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     opB_q, opB_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 isDiv_q, isDiv_d;
   logic                 negRes_q, negRes_d;
   logic                 negRem_q, negRem_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic                 done_q, done_d;

   logic                 isMulOp, isDivOp, signedOp, aNeg, bNeg, launch;
   logic [WIDTH-1:0]     aMag, bMag;
   logic [WIDTH:0]       mulSum;
   logic [2*WIDTH-1:0]   mulStep, divStep, accNeg;
   logic [WIDTH-1:0]     divDiff;
   logic                 divGe;

   assign isMulOp  = (op == OP_MUL) || (op == OP_MULU);
   assign isDivOp  = (op == OP_DIV) || (op == OP_DIVU);
   assign signedOp = (op == OP_MUL) || (op == OP_DIV);
   assign aNeg     = signedOp & a[WIDTH-1];
   assign bNeg     = signedOp & b[WIDTH-1];
   assign aMag     = aNeg ? -a : a;
   assign bMag     = bNeg ? -b : b;

`ifdef MIPS_HILO_FAST_MULT_EN
   logic [2*WIDTH-1:0]   fastProd;
   // Sign-extending to full width makes the truncated product correct for both signednesses
   assign fastProd = {{WIDTH{aNeg}}, a} * {{WIDTH{bNeg}}, b};
   assign launch   = start & isDivOp;
`else
   assign launch   = start & (isDivOp | isMulOp);
`endif

   // Accumulator holds {partial product, multiplier} or {remainder, dividend/quotient}
   assign mulSum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opB_q} : '0);
   assign mulStep = {mulSum, acc_q[WIDTH-1:1]};
   assign divGe   = acc_q[2*WIDTH-1:WIDTH-1] >= {1'b0, opB_q};
   assign divDiff = acc_q[2*WIDTH-2:WIDTH-1] - opB_q;
   assign divStep = divGe ? {divDiff, acc_q[WIDTH-2:0], 1'b1}
                          : {acc_q[2*WIDTH-2:0], 1'b0};
   assign accNeg  = -acc_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         opB_q    <= '0;
         cnt_q    <= '0;
         isDiv_q  <= 1'b0;
         negRes_q <= 1'b0;
         negRem_q <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         opB_q    <= opB_d;
         cnt_q    <= cnt_d;
         isDiv_q  <= isDiv_d;
         negRes_q <= negRes_d;
         negRem_q <= negRem_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      opB_d    = opB_q;
      cnt_d    = cnt_q;
      isDiv_d  = isDiv_q;
      negRes_d = negRes_q;
      negRem_d = negRem_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start && op == OP_MTHI) hi_d = a;
            if (start && op == OP_MTLO) lo_d = a;
            if (launch) begin
               acc_d    = {{WIDTH{1'b0}}, aMag};
               opB_d    = bMag;
               cnt_d    = CNT_W'(WIDTH-1);
               isDiv_d  = isDivOp;
               negRes_d = aNeg ^ bNeg;
               negRem_d = aNeg;
               state_d  = S_RUN;
            end
`ifdef MIPS_HILO_FAST_MULT_EN
            if (start && isMulOp) begin
               {hi_d, lo_d} = fastProd;
               done_d       = 1'b1;
            end
`endif
         end
         S_RUN: begin
            acc_d = isDiv_q ? divStep : mulStep;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == '0) state_d = S_FIXUP;
         end
         S_FIXUP: begin
            // Quotient sign from the operand signs, remainder follows the dividend
            if (isDiv_q) begin
               lo_d = negRes_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
               hi_d = negRem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
            end else begin
               {hi_d, lo_d} = negRes_q ? accNeg : acc_q;
            end
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy = (state_q != S_IDLE) | launch;
   assign hi   = hi_q;
   assign lo   = lo_q;
   assign done = done_q;

endmodule

// File: tb/tb_mips_cpu_hilo_muldiv.sv
// Self-checking bench for mips_cpu_hilo_muldiv: vector table plus scoreboard of HI/LO results.
// Adapts expected multiply latency when MIPS_HILO_FAST_MULT_EN is defined.
module tb_mips_cpu_hilo_muldiv;

   localparam int W = 32;
   localparam logic [4:0] OP_MUL  = 5'd2;
   localparam logic [4:0] OP_DIV  = 5'd3;
   localparam logic [4:0] OP_MULU = 5'd22;
   localparam logic [4:0] OP_DIVU = 5'd23;
   localparam logic [4:0] OP_MTHI = 5'd24;
   localparam logic [4:0] OP_MTLO = 5'd25;
`ifdef MIPS_HILO_FAST_MULT_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset, start;
   logic [4:0]    op;
   logic [W-1:0]  a, b, hi, lo;
   logic          busy, done;

   int nChecks = 0;
   int nErrors = 0;

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] expHi;
      logic [31:0] expLo;
   } vec_t;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          latency;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[16];

   mips_cpu_hilo_muldiv #(.WIDTH(W), .CNT_W(5)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .hi(hi), .lo(lo), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nErrors++;
         $display("[TB] FAIL %s: got %h, wanted %h", name, actual, expected);
      end
   endtask

   function automatic bit isMul(input logic [4:0] o);
      return (o == OP_MUL) || (o == OP_MULU);
   endfunction

   function automatic int expLatency(input logic [4:0] o);
      return (FAST && isMul(o)) ? 0 : 33;
   endfunction

   // Independent reference: wide signed arithmetic, with the divide-by-zero results spelled out
   function automatic logic [63:0] model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
      longint sx, sy, q, r, p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      case (o)
         OP_MULU: return {32'b0, x} * {32'b0, y};
         OP_MUL: begin
            p = sx * sy;
            return p;
         end
         OP_DIVU: return (y == 0) ? {x, 32'hFFFFFFFF} : {x % y, x / y};
         OP_DIV: begin
            if (y == 0) return {x, (x[31] ? 32'h00000001 : 32'hFFFFFFFF)};
            q = sx / sy;
            r = sx % sy;
            return {r[31:0], q[31:0]};
         end
         default: return 64'd0;
      endcase
   endfunction

   task automatic applyStimulus(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      #1;
      if (isMul(o) || o == OP_DIV || o == OP_DIVU)
         checkOutput("busyIssue", 64'(busy), 64'(expLatency(o) != 0));
      tick();
      start = 1'b0;
      op    = 5'd0;
      a     = '0;
      b     = '0;
   endtask

   task automatic waitResult(input string name, input bit pulseCheck);
      logic [31:0] oldHi, oldLo;
      int          cycles, busyCycles;
      exp_t        e;
      oldHi      = hi;
      oldLo      = lo;
      cycles     = 0;
      busyCycles = 0;
      e          = sb.pop_front();
      while (!done && cycles < 100) begin
         if (cycles == 5) begin
            checkOutput({name, " holdHi"}, 64'(hi), 64'(oldHi));
            checkOutput({name, " holdLo"}, 64'(lo), 64'(oldLo));
         end
         if (busy) busyCycles++;
         tick();
         cycles++;
      end
      if (!done) begin
         nChecks++;
         nErrors++;
         $display("[TB] FAIL %s timeout: got no done, wanted done within 100 cycles", name);
      end else begin
         checkOutput({name, " hi"}, 64'(hi), 64'(e.hi));
         checkOutput({name, " lo"}, 64'(lo), 64'(e.lo));
         checkOutput({name, " latency"}, 64'(cycles), 64'(e.latency));
         checkOutput({name, " busyCycles"}, 64'(busyCycles), 64'(e.latency));
      end
      if (pulseCheck) begin
         tick();
         checkOutput({name, " doneOnce"}, 64'(done), 64'd0);
         checkOutput({name, " busyAfter"}, 64'(busy), 64'd0);
      end
   endtask

   task automatic runOp(input string name, input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eHi, input logic [31:0] eLo, input bit pulseCheck);
      exp_t e;
      e.hi = eHi;
      e.lo = eLo;
      e.latency = expLatency(o);
      sb.push_back(e);
      applyStimulus(o, x, y);
      waitResult(name, pulseCheck);
   endtask

   initial begin
      logic [31:0] savedLo, rx, ry;
      logic [4:0]  ro;
      logic [63:0] m;
      bit          sawDone;

      vecs[0]  = '{OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      vecs[1]  = '{OP_MUL,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
      vecs[2]  = '{OP_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3]  = '{OP_DIVU, 32'd100,      32'h00000000, 32'd100,      32'hFFFFFFFF};
      vecs[4]  = '{OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      vecs[5]  = '{OP_DIV,  32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'h00000001};
      vecs[6]  = '{OP_DIV,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF};
      vecs[7]  = '{OP_DIVU, 32'd10,       32'd3,        32'd1,        32'd3};
      vecs[8]  = '{OP_MUL,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      vecs[9]  = '{OP_MUL,  32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2};
      vecs[10] = '{OP_DIV,  32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
      vecs[11] = '{OP_DIV,  32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};
      vecs[12] = '{OP_MULU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
      vecs[13] = '{OP_DIVU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
      vecs[14] = '{OP_DIVU, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32'h00000001};
      vecs[15] = '{OP_DIVU, 32'h80000000, 32'h80000001, 32'h80000000, 32'h00000000};

      reset = 1'b1;
      start = 1'b0;
      op    = 5'd0;
      a     = '0;
      b     = '0;
      tick();
      tick();
      checkOutput("resetHi", 64'(hi), 64'd0);
      checkOutput("resetLo", 64'(lo), 64'd0);
      checkOutput("resetBusy", 64'(busy), 64'd0);
      checkOutput("resetDone", 64'(done), 64'd0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 16; i++)
         runOp($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expHi, vecs[i].expLo, 1'b1);

      for (int i = 0; i < 6; i++) begin
         case ($urandom_range(0, 3))
            0: ro = OP_MUL;
            1: ro = OP_MULU;
            2: ro = OP_DIV;
            default: ro = OP_DIVU;
         endcase
         rx = $urandom();
         ry = (i == 5) ? 32'd0 : $urandom() >> $urandom_range(0, 31);
         m  = model(ro, rx, ry);
         runOp($sformatf("rand%0d", i), ro, rx, ry, m[63:32], m[31:0], 1'b1);
      end

      // MTHI/MTLO write in the issue edge without raising busy or done
      savedLo = lo;
      applyStimulus(OP_MTHI, 32'h12345678, 32'd0);
      checkOutput("mthiHi", 64'(hi), 64'h12345678);
      checkOutput("mthiLo", 64'(lo), 64'(savedLo));
      checkOutput("mthiBusy", 64'(busy), 64'd0);
      checkOutput("mthiDone", 64'(done), 64'd0);
      applyStimulus(OP_MTLO, 32'h9ABCDEF0, 32'd0);
      checkOutput("mtloLo", 64'(lo), 64'h9ABCDEF0);
      checkOutput("mtloHi", 64'(hi), 64'h12345678);

      // MTLO arriving while a DIV is in flight must be dropped
      begin
         exp_t e;
         e.hi = 32'hFFFFFFFF;
         e.lo = 32'hFFFFFFFD;
         e.latency = 29;
         sb.push_back(e);
         applyStimulus(OP_DIV, 32'hFFFFFFF9, 32'd2);
         repeat (3) tick();
         start = 1'b1;
         op    = OP_MTLO;
         a     = 32'h0000DEAD;
         tick();
         start = 1'b0;
         op    = 5'd0;
         a     = '0;
         waitResult("divWithMtlo", 1'b1);
      end

      runOp("b2bDivu", OP_DIVU, 32'd10, 32'd3, 32'd1, 32'd3, 1'b0);
      runOp("b2bMulu", OP_MULU, 32'd3, 32'd1, 32'd0, 32'd3, 1'b1);

      // Reset ten cycles into a DIVU: no result may ever appear
      applyStimulus(OP_DIVU, 32'd100, 32'd7);
      repeat (9) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("abortHi", 64'(hi), 64'd0);
      checkOutput("abortLo", 64'(lo), 64'd0);
      checkOutput("abortBusy", 64'(busy), 64'd0);
      applyStimulus(OP_MTLO, 32'd5, 32'd0);
      checkOutput("abortMtlo", 64'(lo), 64'd5);
      sawDone = 1'b0;
      repeat (40) begin
         tick();
         if (done) sawDone = 1'b1;
      end
      checkOutput("abortNoDone", 64'(sawDone), 64'd0);
      checkOutput("abortLoKept", 64'(lo), 64'd5);

      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

endmodule

// File: doc/mips_cpu_hilo_muldiv.md
Name: mips_cpu_hilo_muldiv

Overview:
- Multi-cycle multiply/divide unit that owns the HI and LO special registers.
- Sits directly downstream of the control decoder.
- Consumes CtrlALUOp codes MUL(2), MULU(22), DIV(3), DIVU(23), MTHI(24) and MTLO(25) when CtrlSpcRegWriteEn is high, and drives the HI/LO values selected by CtrlMemtoReg 3/4 (MFHI/MFLO).
- Raises busy so the datapath stalls while an iterative operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO register width.
- CNT_W, 5, iteration counter width; holds WIDTH-1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  qualifies op; driven by CtrlSpcRegWriteEn.
- op  input  5  ALU op code from control: 2 MUL, 22 MULU, 3 DIV, 23 DIVU, 24 MTHI, 25 MTLO.
- a  input  WIDTH  rs operand / dividend / MTHI-MTLO source.
- b  input  WIDTH  rt operand / divisor.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- busy  output  1  high while an operation is in progress; the datapath stalls on it.
- done  output  1  one-cycle pulse when HI/LO are updated by mult/div.

Behaviour:
- Reset (synchronous, active-high): hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0. Reset mid-operation aborts the operation; no partial result is written.
- States: IDLE, RUN, FIXUP.
- IDLE:
  - start=1 with op=MTHI: hi<=a at this edge; lo unchanged; stays IDLE; busy stays 0; no done.
  - start=1 with op=MTLO: same, but lo<=a.
  - start=1 with op in {MUL, MULU, DIV, DIVU}: latch |a| and |b| (magnitudes for signed ops, raw for unsigned), the result-sign flags and the op; counter<=WIDTH-1; go to RUN.
  - start=1 with any other op: ignored.
- RUN: one iteration per cycle, WIDTH cycles total.
  - Multiply: shift-add into a 2*WIDTH accumulator, one multiplier bit per cycle.
  - Divide: restoring division, one quotient bit per cycle.
  - Leaves for FIXUP when counter==0; counter decrements each cycle.
- FIXUP (one cycle):
  - Apply two's-complement negation for signed ops.
  - MUL: product negated if sign(a) xor sign(b).
  - DIV: quotient truncates toward zero and is negated if the signs differ; remainder takes the sign of the dividend.
  - At the closing edge: hi<=product[63:32] or remainder; lo<=product[31:0] or quotient; done<=1 for the next cycle; return to IDLE.
- Latency: start sampled at edge E0; hi/lo updated at edge E0+WIDTH+1 (E0+33); done high during the cycle following that edge.
- busy:
  - Asserted combinationally in IDLE when start=1 with a mult/div op, so the stall takes effect in the issue cycle.
  - High throughout RUN and FIXUP; low otherwise.
- start while in RUN or FIXUP: ignored, including MTHI and MTLO.
- hi and lo hold their previous values throughout RUN and FIXUP; MFHI/MFLO during busy read the old values.
- Divide by zero (b==0): completes in normal latency with no trap. DIVU: lo=0xFFFFFFFF, hi=a. DIV: lo=0xFFFFFFFF if a>=0 else 0x00000001, hi=a.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wraps, no exception).
- Arithmetic is modulo 2^WIDTH per half; no overflow flag.

Optional Feature:
- Macro: MIPS_HILO_FAST_MULT_EN.
- Defined: MUL/MULU complete in one cycle. hi/lo are written at edge E0 from a full 64-bit signed or unsigned product; no RUN/FIXUP states are entered; busy stays 0; done pulses the cycle after E0. DIV/DIVU are unchanged.
- Undefined: multiply uses the iterative path with the latency above.

Test Plan:
- Reset mid-DIVU (assert reset at cycle 10 after start) -> hi=0, lo=0, busy=0 on the next cycle; a following MTLO a=5 -> lo=5.
- MULU a=0xFFFFFFFF, b=0xFFFFFFFF -> after 33 cycles hi=0xFFFFFFFE, lo=0x00000001; done pulses exactly once; busy high for 33 cycles.
- MUL a=-3 (0xFFFFFFFD), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; with MIPS_HILO_FAST_MULT_EN the same result appears 1 cycle after start and busy never asserts.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=100.
- MTHI a=0x12345678 while idle -> hi=0x12345678 next cycle, lo unchanged; MTLO issued during an in-flight DIV -> ignored, and the DIV result is written normally.
- Back-to-back: DIVU 10/3 completes (lo=3, hi=1), start MULT asserted in the done cycle -> accepted, result 3*1 -> lo=3, hi=0.
